// File: rtl/stream_demux_reg.sv
// Registered 1-to-NUM_OUT stream demux with optional broadcast.
// Each channel has a one-entry holding register; beats with out-of-range selects are counted and dropped.
module stream_demux_reg #(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2,
  parameter int ERR_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [ERR_W-1:0]         err_count
);

  localparam logic [SEL_W:0] NUM_OUT_EXT = (SEL_W+1)'(NUM_OUT);

  logic [NUM_OUT-1:0] r_valid;
  logic [WIDTH-1:0]   r_data [NUM_OUT];
  logic [ERR_W-1:0]   r_err;

  logic [NUM_OUT-1:0] w_free;
  logic [NUM_OUT-1:0] w_hit;
  logic [NUM_OUT-1:0] w_load;
  logic               w_selOk;
  logic               w_accept;
  logic               w_drop;

  assign w_free  = ~r_valid | out_ready;
  assign w_selOk = ({1'b0, in_sel} < NUM_OUT_EXT);

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
    assign w_hit[k]                   = (in_sel == SEL_W'(k));
    assign out_data[k*WIDTH +: WIDTH] = r_data[k];
  end

  // Broadcast needs every slot free so it is all-or-nothing; bad selects are always sunk.
  always_comb begin
    in_ready = 1'b1;
    if (in_bcast) begin
      in_ready = &w_free;
    end else if (w_selOk) begin
      in_ready = |(w_hit & w_free);
    end
  end

  assign w_accept = in_valid && in_ready;
  assign w_drop   = w_accept && !in_bcast && !w_selOk;
  assign w_load   = {NUM_OUT{w_accept}} & ({NUM_OUT{in_bcast}} | w_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int k = 0; k < NUM_OUT; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= in_data;
        end else if (out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= '0;
    end else if (w_drop && (r_err != '1)) begin
      r_err <= r_err + ERR_W'(1);
    end
  end

  assign out_valid = r_valid;
  assign err_count = r_err;

endmodule

// File: doc/stream_demux_reg.md
Name: stream_demux_reg

Overview:
- Parametrised, registered successor to the 1-to-4 gate-level demux.
- Routes a WIDTH-bit valid/ready stream to one of NUM_OUT output channels chosen by in_sel, or to all channels when in_bcast is set.
- Each output has a one-entry holding register, so the block provides backpressure per channel and isolates timing between the source and its consumers.
- Sits between a single producer and NUM_OUT independent consumers in the datapath.

Parameters:
- WIDTH, 8, data width per beat.
- NUM_OUT, 4, number of output channels (2..16).
- SEL_W, 2, width of in_sel. Must satisfy 2**SEL_W >= NUM_OUT.
- ERR_W, 8, width of the saturating bad-select counter.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_data, input, WIDTH, input beat.
- in_sel, input, SEL_W, target channel index.
- in_bcast, input, 1, 1 = deliver the beat to every channel.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, block can accept the beat this cycle.
- out_data, output, NUM_OUT*WIDTH, channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid, output, NUM_OUT, per-channel valid.
- out_ready, input, NUM_OUT, per-channel ready.
- err_count, output, ERR_W, count of beats dropped because of a bad select.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
  - Reset clears out_valid to all 0, out_data to 0 and err_count to 0. Reset overrides any handshake in the same cycle, and any beat held in a channel register is discarded.
- Channel state:
  - Each channel k has a holding register (data_k, valid_k); out_valid[k] = valid_k.
  - free_k = !valid_k || out_ready[k], i.e. the slot is empty or is draining this cycle.
- in_ready (combinational from state, in_sel, in_bcast and out_ready; never from in_valid):
  - When in_bcast=1: in_ready = AND of free_k over all k.
  - When in_bcast=0 and in_sel < NUM_OUT: in_ready = free_[in_sel].
  - When in_bcast=0 and in_sel >= NUM_OUT: in_ready = 1, because the beat is sunk.
- Accept condition: accept = in_valid && in_ready.
- On accept with in_bcast=1:
  - Every channel loads in_data and sets valid_k=1.
  - in_sel is ignored.
- On accept with in_bcast=0 and a valid select:
  - Channel in_sel loads in_data and sets valid=1.
  - All other channels are untouched.
- On accept with in_bcast=0 and in_sel >= NUM_OUT:
  - The beat is dropped and no channel changes.
  - err_count increments by 1 and saturates at 2**ERR_W-1.
- Per-channel update:
  - If the channel is loaded this cycle, valid_k=1 and data_k=in_data, even if it is also draining; this gives back-to-back throughput of one beat per cycle per channel.
  - Else if out_ready[k] && valid_k, then valid_k=0. data_k holds its old value and is don't-care.
  - Else the channel holds.
- Latency: an accepted beat appears on out_valid/out_data on the cycle after acceptance.
- Ordering and stability:
  - Per-channel order is preserved.
  - While out_valid[k]=1 and out_ready[k]=0, out_data for channel k is stable.
- Broadcast is all-or-nothing. A partial broadcast never occurs; if any channel is full and stalled, in_ready=0 and no channel is written.
- Bad selects are only possible when NUM_OUT < 2**SEL_W. When NUM_OUT = 2**SEL_W, err_count stays 0.
- Outputs carry no combinational path from in_data to out_data.

Test Plan:
1. Reset, then with all out_ready=1 send in_sel=2 and in_data=0xA5 -> next cycle out_valid=4'b0100 and channel 2 data=0xA5; the following cycle out_valid=0.
2. Hold out_ready[1]=0, then send two beats with in_sel=1 (0x11 and 0x22) -> 0x11 is accepted and in_ready=0 for the second beat; channel 1 holds 0x11. Raise out_ready[1] -> 0x22 is accepted in the same cycle and channel 1 shows 0x22 on the next cycle.
3. Broadcast 0x3C with out_ready[3]=0 and channel 3 full -> in_ready=0 and no channel changes. Release out_ready[3] -> all four channels show 0x3C one cycle later.
4. With NUM_OUT=3 and SEL_W=2, send in_sel=3 three times -> in_ready=1, out_valid stays 0 and err_count=3. With ERR_W=2, send four more bad beats -> err_count saturates at 3.
5. Stream 8 beats to channel 0 continuously with out_ready[0]=1 -> one beat per cycle, in order, with no bubbles.
6. Assert reset while channels 0 and 2 hold beats and in_valid=1 -> next cycle out_valid=0 and err_count=0, and no beat is accepted.
